// File: rtl/hub75_pkg.sv
// Shared panel geometry and scan state encoding for the HUB-75 scan driver.
package hub75_pkg;

  localparam int PANEL_WIDTH  = 64;
  localparam int PANEL_HEIGHT = 64;
  localparam int SCAN_ROWS    = 32;

  // One request per half-column pixel: upper and lower line for each column.
  localparam int SHIFT_CYCLES = 2 * PANEL_WIDTH;

  typedef enum logic [2:0] {
    ST_SHIFT,
    ST_DRAIN,
    ST_LATCH,
    ST_DISPLAY,
    ST_BLANK
  } scan_state_t;

endpackage

// File: rtl/hub75_pixel_pair_collector.sv
// Tracks in-flight pixel requests and pairs each upper-line response with the
// following lower-line response, presenting both on the HUB-75 data lines
// for one cycle with the shift clock low and one cycle with it high.
module hub75_pixel_pair_collector
  import hub75_pkg::*;
#(
  parameter int PIXEL_LATENCY = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic req_vld,
  input  logic req_lower,
  input  logic r,
  input  logic g,
  input  logic b,
  output logic hub_clk,
  output logic hub_r1,
  output logic hub_g1,
  output logic hub_b1,
  output logic hub_r2,
  output logic hub_g2,
  output logic hub_b2
);

  logic       vld_p [PIXEL_LATENCY];
  logic       low_p [PIXEL_LATENCY];
  logic [2:0] upper_p0;
  logic       pair_vld_p1;
  logic       cap_upper;
  logic       cap_lower;

  // The last stage lines up with the response currently on r/g/b.
  assign cap_upper = vld_p[PIXEL_LATENCY-1] && !low_p[PIXEL_LATENCY-1];
  assign cap_lower = vld_p[PIXEL_LATENCY-1] &&  low_p[PIXEL_LATENCY-1];

  // Request valid pipeline; cleared on reset so pre-reset requests are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIXEL_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= req_vld;
      for (int i = 1; i < PIXEL_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Upper/lower tag travelling alongside the valid pipeline.
  always_ff @(posedge clock) begin
    low_p[0] <= req_lower;
    for (int i = 1; i < PIXEL_LATENCY; i++) low_p[i] <= low_p[i-1];
  end

  // ---- stage p0: hold the upper-line response until its lower partner arrives
  // Capture the upper pixel of the current column.
  always_ff @(posedge clock) begin
    if (cap_upper) upper_p0 <= {r, g, b};
  end

  // ---- stage p1: drive the pair with hub_clk low, then raise hub_clk
  // Load both triplets on the lower response and pulse hub_clk one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_vld_p1 <= 1'b0;
      hub_clk     <= 1'b0;
      hub_r1      <= 1'b0;
      hub_g1      <= 1'b0;
      hub_b1      <= 1'b0;
      hub_r2      <= 1'b0;
      hub_g2      <= 1'b0;
      hub_b2      <= 1'b0;
    end else begin
      pair_vld_p1 <= cap_lower;
      hub_clk     <= pair_vld_p1;
      if (cap_lower) begin
        {hub_r1, hub_g1, hub_b1} <= upper_p0;
        {hub_r2, hub_g2, hub_b2} <= {r, g, b};
      end
    end
  end

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB-75 1/32-scan driver for a 64x64 panel: requests pixels from an external
// fixed-latency source, shifts each row out, latches it and displays it.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int PIXEL_LATENCY = 2,
  parameter int OE_CYCLES     = 64,
  parameter int BLANK_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic [5:0] x,
  output logic [5:0] y,
  output logic [9:0] t,
  input  logic       r,
  input  logic       g,
  input  logic       b,
  output logic       hub_clk,
  output logic       hub_lat,
  output logic       hub_oe_n,
  output logic [4:0] hub_addr,
  output logic       hub_r1,
  output logic       hub_g1,
  output logic       hub_b1,
  output logic       hub_r2,
  output logic       hub_g2,
  output logic       hub_b2
);

  scan_state_t state;
  logic [15:0] cnt;
  logic [4:0]  row;

  // In SHIFT, even cycles fetch the upper line and odd cycles the lower line
  // of column cnt>>1; the lower line sits 32 rows below, i.e. y = {cnt[0], row}.
  assign x = (state == ST_SHIFT) ? cnt[6:1]     : 6'd0;
  assign y = (state == ST_SHIFT) ? {cnt[0], row} : 6'd0;

  // Scan sequencer: SHIFT -> DRAIN -> LATCH -> DISPLAY -> BLANK, with
  // latch, output enable and row address registered on state entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_SHIFT;
      cnt      <= '0;
      row      <= '0;
      t        <= '0;
      hub_lat  <= 1'b0;
      hub_oe_n <= 1'b1;
      hub_addr <= '0;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (cnt == 16'(SHIFT_CYCLES - 1)) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DRAIN: begin
          // Wait out the source latency plus the two collector stages.
          if (cnt == 16'(PIXEL_LATENCY + 1)) begin
            state    <= ST_LATCH;
            cnt      <= '0;
            hub_lat  <= 1'b1;
            hub_addr <= row;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_LATCH: begin
          state    <= ST_DISPLAY;
          hub_lat  <= 1'b0;
          hub_oe_n <= 1'b0;
        end
        ST_DISPLAY: begin
          if (cnt == 16'(OE_CYCLES - 1)) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            hub_oe_n <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_BLANK: begin
          if (cnt == 16'(BLANK_CYCLES - 1)) begin
            state <= ST_SHIFT;
            cnt   <= '0;
            row   <= row + 5'd1;
            if (row == 5'(SCAN_ROWS - 1)) t <= t + 10'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_SHIFT;
          cnt   <= '0;
        end
      endcase
    end
  end

  hub75_pixel_pair_collector #(
    .PIXEL_LATENCY(PIXEL_LATENCY)
  ) u_collector (
    .clock    (clock),
    .reset    (reset),
    .req_vld  (state == ST_SHIFT),
    .req_lower(cnt[0]),
    .r        (r),
    .g        (g),
    .b        (b),
    .hub_clk  (hub_clk),
    .hub_r1   (hub_r1),
    .hub_g1   (hub_g1),
    .hub_b1   (hub_b1),
    .hub_r2   (hub_r2),
    .hub_g2   (hub_g2),
    .hub_b2   (hub_b2)
  );

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Testbench for hub75_scan_driver: a pixel source model with a frame image,
// a cycle-level timing reference and a scoreboard for shifted pixel pairs.
module tb_hub75_scan_driver;
  import hub75_pkg::*;

  localparam int LA = 2, OEA = 64, BLA = 2;
  localparam int LB = 4, OEB = 8,  BLB = 1;
  localparam int PA = 131 + LA + OEA + BLA;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic [9:0] t;
    logic       clk;
    logic       lat;
    logic       oe_n;
    logic [4:0] addr;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [5:0] x_a, y_a, x_b, y_b;
  logic [9:0] t_a, t_b;
  logic       r_a, g_a, b_a, r_b, g_b, b_b;
  logic       clk_a, lat_a, oe_a, clk_b, lat_b, oe_b;
  logic [4:0] addr_a, addr_b;
  logic [5:0] data_a, data_b;
  obs_t       obs_a, obs_b;

  assign obs_a = {x_a, y_a, t_a, clk_a, lat_a, oe_a, addr_a};
  assign obs_b = {x_b, y_b, t_b, clk_b, lat_b, oe_b, addr_b};

  hub75_scan_driver #(.PIXEL_LATENCY(LA), .OE_CYCLES(OEA), .BLANK_CYCLES(BLA)) dut_a (
    .clock(clock), .reset(reset), .x(x_a), .y(y_a), .t(t_a),
    .r(r_a), .g(g_a), .b(b_a),
    .hub_clk(clk_a), .hub_lat(lat_a), .hub_oe_n(oe_a), .hub_addr(addr_a),
    .hub_r1(data_a[5]), .hub_g1(data_a[4]), .hub_b1(data_a[3]),
    .hub_r2(data_a[2]), .hub_g2(data_a[1]), .hub_b2(data_a[0])
  );

  hub75_scan_driver #(.PIXEL_LATENCY(LB), .OE_CYCLES(OEB), .BLANK_CYCLES(BLB)) dut_b (
    .clock(clock), .reset(reset), .x(x_b), .y(y_b), .t(t_b),
    .r(r_b), .g(g_b), .b(b_b),
    .hub_clk(clk_b), .hub_lat(lat_b), .hub_oe_n(oe_b), .hub_addr(addr_b),
    .hub_r1(data_b[5]), .hub_g1(data_b[4]), .hub_b1(data_b[3]),
    .hub_r2(data_b[2]), .hub_g2(data_b[1]), .hub_b2(data_b[0])
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit phase_a = 1'b1;
  logic [2:0] img [PANEL_HEIGHT][PANEL_WIDTH];
  logic [5:0] exp_q [$];
  int first_rise_b = -1;
  int lat_b_cyc [2] = '{-1, -1};
  int n_lat_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Timing reference derived from the row schedule: row period, SHIFT
  // addressing, latch/enable windows and the hub_clk high cycles.
  function automatic obs_t model(input int c, input int L, input int OE, input int BL);
    int   p, rc, row;
    obs_t m;
    p   = 131 + L + OE + BL;
    rc  = c % p;
    row = (c / p) % SCAN_ROWS;
    m   = '0;
    if (rc < 2 * PANEL_WIDTH) begin
      m.x = 6'(rc / 2);
      m.y = 6'(row + SCAN_ROWS * (rc % 2));
    end
    m.t    = 10'((c / (p * SCAN_ROWS)) % 1024);
    m.lat  = (rc == 130 + L);
    m.oe_n = !(rc >= 131 + L && rc < 131 + L + OE);
    if (rc >= 130 + L) m.addr = 5'(row);
    else if (c >= p)   m.addr = 5'((row + SCAN_ROWS - 1) % SCAN_ROWS);
    m.clk  = (rc >= L + 3) && (rc <= L + 129) && ((rc - L - 3) % 2 == 0);
    return m;
  endfunction

  // Cycle counter: 0 is the first cycle after reset release.
  initial begin
    forever begin
      @(posedge clock);
      if (reset) cyc = 0;
      else       cyc = cyc + 1;
    end
  end

  // Pixel source for both instances with their own latencies; also issues
  // the expected column pairs of each row as it begins.
  initial begin
    logic [2:0] hist_a [LA+1];
    logic [2:0] hist_b [LB+1];
    int row;
    for (int i = 0; i <= LA; i++) hist_a[i] = '0;
    for (int i = 0; i <= LB; i++) hist_b[i] = '0;
    {r_a, g_a, b_a} = '0;
    {r_b, g_b, b_b} = '0;
    forever begin
      @(negedge clock);
      for (int i = LA; i > 0; i--) hist_a[i] = hist_a[i-1];
      hist_a[0] = img[y_a][x_a];
      {r_a, g_a, b_a} = hist_a[LA];
      for (int i = LB; i > 0; i--) hist_b[i] = hist_b[i-1];
      hist_b[0] = img[y_b][x_b];
      {r_b, g_b, b_b} = hist_b[LB];
      if (chk_en && (cyc % PA) == 0) begin
        row = (cyc / PA) % SCAN_ROWS;
        for (int c = 0; c < PANEL_WIDTH; c++)
          exp_q.push_back({img[row][c], img[row + SCAN_ROWS][c]});
      end
    end
  end

  // Monitor A: per-cycle timing, and on every hub_clk rise pop the expected
  // pair and compare it with both the low-clock and the high-clock data.
  initial begin
    logic       prev_clk;
    logic [5:0] prev_data;
    logic [5:0] e;
    int         rises;
    prev_clk = 1'b0; prev_data = '0; rises = 0;
    forever begin
      @(negedge clock);
      if (!chk_en) begin
        prev_clk = 1'b0;
        rises    = 0;
      end else begin
        check("timing_a", 64'(obs_a), 64'(model(cyc, LA, OEA, BLA)));
        if (clk_a && !prev_clk) begin
          rises++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pair_a cyc=%0d got=%h expected=none (queue empty)", cyc, data_a);
          end else begin
            e = exp_q.pop_front();
            check("pair_setup_a", 64'(prev_data), 64'(e));
            check("pair_hold_a", 64'(data_a), 64'(e));
          end
        end
        if ((cyc % PA) == PA - 1) begin
          check("rises_per_row_a", 64'(rises), 64'd64);
          check("queue_left_a", 64'(exp_q.size()), 64'd0);
          rises = 0;
        end
        prev_clk  = clk_a;
        prev_data = data_a;
      end
    end
  end

  // Monitor B: timing reference for the short-row instance plus first-rise
  // and latch-period capture after the first reset release.
  initial begin
    logic prev_clk;
    prev_clk = 1'b0;
    forever begin
      @(negedge clock);
      if (!chk_en) begin
        prev_clk = 1'b0;
      end else begin
        check("timing_b", 64'(obs_b), 64'(model(cyc, LB, OEB, BLB)));
        if (phase_a) begin
          if (clk_b && !prev_clk && first_rise_b < 0) first_rise_b = cyc;
          if (lat_b && n_lat_b < 2) begin
            lat_b_cyc[n_lat_b] = cyc;
            n_lat_b++;
          end
        end
        prev_clk = clk_b;
      end
    end
  end

  task automatic wait_row_cycle(input int target);
    for (int i = 0; i < 2 * PA; i++) begin
      if ((cyc % PA) == target) break;
      @(negedge clock);
    end
    check("wait_row_cycle", 64'(cyc % PA), 64'(target));
  endtask

  task automatic reset_mid_row(input int at_rc, input int hold);
    obs_t er;
    @(negedge clock);
    wait_row_cycle(at_rc);
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    er = '0;
    er.oe_n = 1'b1;
    check("async_reset_a", {28'd0, obs_a, data_a}, {28'd0, er, 6'd0});
    check("async_reset_b", {28'd0, obs_b, data_b}, {28'd0, er, 6'd0});
    for (int yy = 0; yy < PANEL_HEIGHT; yy++)
      for (int xx = 0; xx < PANEL_WIDTH; xx++)
        img[yy][xx] = 3'($urandom_range(0, 7));
    repeat (hold) @(posedge clock);
    #1;
    exp_q.delete();
    reset  = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Source pattern: r = x[0], g = y[5], b = 1.
    for (int yy = 0; yy < PANEL_HEIGHT; yy++)
      for (int xx = 0; xx < PANEL_WIDTH; xx++)
        img[yy][xx] = {xx[0], yy[5], 1'b1};
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    // One full frame plus two rows: covers the row 31 -> 0 wrap and t 0 -> 1.
    while (cyc < SCAN_ROWS * PA + 2 * PA) @(negedge clock);
    phase_a = 1'b0;
    // Random image, reset in mid-SHIFT (cycle 40) for 3 cycles.
    reset_mid_row(40, 3);
    while (cyc < 3 * PA + 5) @(negedge clock);
    // Random image, reset in mid-DRAIN for 2 cycles.
    reset_mid_row(130, 2);
    while (cyc < 2 * PA + 5) @(negedge clock);
    check("first_rise_b", 64'(first_rise_b), 64'd7);
    check("row_period_b", 64'(lat_b_cyc[1] - lat_b_cyc[0]), 64'd144);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hub75_scan_driver.md
HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

Interface
REQ-001 SHALL have parameter PIXEL_LATENCY, default 2: fixed cycles from an x/y request to its r/g/b response.
REQ-002 SHALL have parameter OE_CYCLES, default 64: cycles per row with the panel output enabled.
REQ-003 SHALL have parameter BLANK_CYCLES, default 2: cycles per row with the panel blanked after display.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports x and y, outputs, 6 bits each: pixel coordinate requested from the pixel source.
REQ-007 SHALL have port t, output, 10 bits: frame counter fed to the pixel source.
REQ-008 SHALL have ports r, g and b, inputs, 1 bit each: pixel response, valid PIXEL_LATENCY cycles after its request.
REQ-009 SHALL have ports hub_clk, hub_lat and hub_oe_n, outputs, 1 bit each: HUB-75 shift clock, latch and active-low output enable.
REQ-010 SHALL have port hub_addr, output, 5 bits: HUB-75 row address A-E.
REQ-011 SHALL have ports hub_r1, hub_g1, hub_b1, hub_r2, hub_g2 and hub_b2, outputs, 1 bit each: upper-half and lower-half serial data.

Function
REQ-012 SHALL scan a 64x64 panel at 1/32 scan; row register 0..31 drives upper line y=row and lower line y=row+32.
REQ-013 SHALL use the state sequence SHIFT(128) -> DRAIN(PIXEL_LATENCY+2) -> LATCH(1) -> DISPLAY(OE_CYCLES) -> BLANK(BLANK_CYCLES) -> SHIFT, with cycle counts in parentheses.
REQ-014 SHALL, in SHIFT cycle k (0..127), drive x=k>>1, and y=row when k is even, y=row+32 when k is odd.
REQ-015 SHALL drive x=0 and y=0 outside SHIFT.
REQ-016 SHALL track in-flight requests with a PIXEL_LATENCY-deep valid pipeline, and capture r/g/b only when the matching valid bit is set.
REQ-017 SHALL register each captured upper response, and on the following lower response drive both data triplets with hub_clk=0 in the next cycle and hub_clk=1 in the cycle after.
REQ-018 SHALL, relative to SHIFT start, place column c data at cycle PIXEL_LATENCY+2+2c with hub_clk=0 and at cycle PIXEL_LATENCY+3+2c with hub_clk=1; exactly 64 hub_clk rising edges per row.
REQ-019 SHALL hold the data lines stable while hub_clk=1, and hold hub_clk=0 outside the hub_clk=1 cycles.
REQ-020 SHALL, in LATCH, assert hub_lat for exactly one cycle with hub_oe_n=1, and load hub_addr=row in that same cycle.
REQ-021 SHALL hold hub_oe_n=0 in DISPLAY only; hub_oe_n=1 in every other state.
REQ-022 SHALL increment row at the end of BLANK, wrapping 31->0.
REQ-023 SHALL increment t by 1 when row wraps, wrapping 1023->0.
REQ-024 SHALL give a row period of 131+PIXEL_LATENCY+OE_CYCLES+BLANK_CYCLES cycles; the defaults give 199 cycles per row and 6368 cycles per frame.

Reset
REQ-025 SHALL force, on reset assertion (asynchronously): state=SHIFT, row=0, t=0, SHIFT counter=0, valid pipeline cleared.
REQ-026 SHALL force all outputs on reset assertion to 0, except hub_oe_n=1.
REQ-027 SHALL never shift out responses to requests issued before reset, including reset mid-SHIFT or mid-DRAIN.
REQ-028 SHALL, on the first clock after reset release, be in SHIFT cycle 0.

Structure
REQ-029 SHALL define in shared package hub75_pkg: PANEL_WIDTH=64, PANEL_HEIGHT=64, SCAN_ROWS=32, and the scan state enum.
REQ-030 SHALL implement the valid pipeline plus upper/lower pair capture as one sub-module, hub75_pixel_pair_collector, parameterised by PIXEL_LATENCY.

Verification
REQ-031 SHALL cover reset release: over cycles 0..127, x = 0,0,1,1,...,63,63 and y alternates 0,32; hub_oe_n=1 and hub_lat=0 throughout.
REQ-032 SHALL cover the data path with a source model (latency 2) returning r=x[0], g=y[5], b=1: at each hub_clk rise, hub_r1=hub_r2=column parity, hub_g1=0, hub_g2=1, hub_b1=hub_b2=1; 64 rises per row.
REQ-033 SHALL cover row timing at defaults: hub_lat=1 only at cycle 132, where hub_addr becomes row; hub_oe_n=0 over cycles 133..196; next SHIFT starts at cycle 199.
REQ-034 SHALL cover frame wrap: after row 31, hub_addr=0 at the next LATCH and t goes 0->1 at cycle 6368.
REQ-035 SHALL cover reset asserted at SHIFT cycle 40 for 3 cycles: outputs reach reset values immediately; after release, hub_clk stays 0 for 4 cycles, then the column 0 sequence restarts.
REQ-036 SHALL cover PIXEL_LATENCY=4, OE_CYCLES=8, BLANK_CYCLES=1: the first hub_clk rise is at cycle 7 and the row period is 144 cycles.
